// File: rtl/parking_gate_controller_if.sv
// rtl/parking_gate_controller_if.sv - sensor, gate and count signals of the parking gate controller
// master drives sensors/requests and reads counts; slave is the controller side.
interface parking_gate_controller_if #(
  parameter int SLOTS = 8,
  parameter int CNT_W = $clog2(SLOTS + 1)
);
  logic [SLOTS-1:0] slot_free;
  logic             entry_req;
  logic             car_passed;
  logic [CNT_W-1:0] free_cnt;
  logic [CNT_W-1:0] parked_cnt;
  logic [CNT_W-1:0] avail_cnt;
  logic             full;
  logic             gate_open;
  logic             entry_deny;

  modport master (
    output slot_free, entry_req, car_passed,
    input  free_cnt, parked_cnt, avail_cnt, full, gate_open, entry_deny
  );

  modport slave (
    input  slot_free, entry_req, car_passed,
    output free_cnt, parked_cnt, avail_cnt, full, gate_open, entry_deny
  );
endinterface

// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - slot counting, in-transit car tracking and entry gate FSM
// All count outputs derive from registers; the lot reads full out of reset until sensors propagate.
module parking_gate_controller #(
  parameter int SLOTS        = 8,
  parameter int CNT_W        = $clog2(SLOTS + 1),
  parameter int OPEN_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  parking_gate_controller_if.slave       bus
);
  localparam int TMR_W = (OPEN_TIMEOUT > 1) ? $clog2(OPEN_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] T_LAST  = TMR_W'(OPEN_TIMEOUT - 1);
  localparam logic [CNT_W:0]   SLOTS_X = (CNT_W + 1)'(SLOTS);

  typedef enum logic [1:0] {ST_IDLE, ST_OPEN, ST_CLOSE} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [SLOTS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CNT_W-1:0] free_cnt_q, free_cnt_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             req_prev_q, req_prev_d;
  logic             deny_q, deny_d;
  logic             req_edge, passed;
  logic [CNT_W-1:0] avail, drop;
  logic [CNT_W:0]   pend_sum, pend_net;

  always_comb begin
    sync1_d    = bus.slot_free;
    sync2_d    = sync1_q;
    req_prev_d = bus.entry_req;
    free_cnt_d = '0;
    for (int i = 0; i < SLOTS; i++) begin
      free_cnt_d = free_cnt_d + CNT_W'(sync2_q[i]);
    end
  end

  assign req_edge = bus.entry_req & ~req_prev_q;
  assign avail    = (free_cnt_q > pending_q) ? (free_cnt_q - pending_q) : '0;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    deny_d  = 1'b0;
    passed  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (req_edge) begin
          if (avail != '0) state_d = ST_OPEN;
          else             deny_d  = 1'b1;
        end
      end
      ST_OPEN: begin
        // car_passed takes priority over a timeout in the same cycle
        if (bus.car_passed) begin
          passed  = 1'b1;
          state_d = ST_CLOSE;
          timer_d = '0;
        end else if (timer_q == T_LAST) begin
          state_d = ST_CLOSE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_CLOSE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Only a falling free count retires in-transit cars; departures leave pending alone.
  always_comb begin
    drop     = (free_cnt_d < free_cnt_q) ? (free_cnt_q - free_cnt_d) : '0;
    pend_sum = {1'b0, pending_q} + {{CNT_W{1'b0}}, passed};
    pend_net = pend_sum - {1'b0, drop};
    if ({1'b0, drop} >= pend_sum) pending_d = '0;
    else if (pend_net > SLOTS_X)  pending_d = CNT_W'(SLOTS);
    else                          pending_d = pend_net[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      free_cnt_q <= '0;
      pending_q  <= '0;
      req_prev_q <= 1'b0;
      deny_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      free_cnt_q <= free_cnt_d;
      pending_q  <= pending_d;
      req_prev_q <= req_prev_d;
      deny_q     <= deny_d;
    end
  end

  assign bus.free_cnt   = free_cnt_q;
  assign bus.parked_cnt = CNT_W'(SLOTS) - free_cnt_q;
  assign bus.avail_cnt  = avail;
  assign bus.full       = (avail == '0);
  assign bus.gate_open  = (state_q == ST_OPEN);
  assign bus.entry_deny = deny_q;
endmodule

// File: tb/tb_parking_gate_controller.sv
// tb/tb_parking_gate_controller.sv - scoreboard bench for parking_gate_controller
module tb_parking_gate_controller;
  localparam int SLOTS = 8;
  localparam int OT    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  parking_gate_controller_if #(.SLOTS(SLOTS)) bus ();

  parking_gate_controller #(.SLOTS(SLOTS), .OPEN_TIMEOUT(OT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int free_c;
    int parked;
    int avail;
    int full;
    int gate;
    int deny;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // reference model: lot-level quantities only
  logic [7:0] sf_hist[$];
  int m_free, m_pend, m_age;
  bit m_open, m_closing, m_deny, m_prev;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endfunction

  function automatic int m_avail();
    return (m_free > m_pend) ? m_free - m_pend : 0;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.free_c = m_free;
    e.parked = SLOTS - m_free;
    e.avail  = m_avail();
    e.full   = (m_avail() == 0);
    e.gate   = m_open;
    e.deny   = m_deny;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    sf_hist.delete();
    sf_hist.push_back(8'h00);
    sf_hist.push_back(8'h00);
    m_free = 0; m_pend = 0; m_age = 0;
    m_open = 0; m_closing = 0; m_deny = 0; m_prev = 0;
  endtask

  task automatic model_step(input logic [7:0] sf, input bit req, input bit cp);
    int fo, d, p;
    bit rise, acc;
    rise   = req && !m_prev;
    m_prev = req;
    m_deny = 0;
    acc    = 0;
    if (m_closing) begin
      m_closing = 0;
    end else if (m_open) begin
      if (cp) begin
        acc = 1; m_open = 0; m_closing = 1;
      end else if (m_age == OT - 1) begin
        m_open = 0; m_closing = 1;
      end else begin
        m_age++;
      end
    end else if (rise) begin
      if (m_avail() > 0) begin
        m_open = 1; m_age = 0;
      end else begin
        m_deny = 1;
      end
    end
    fo = m_free;
    sf_hist.push_back(sf);
    m_free = $countones(sf_hist.pop_front());
    d = (fo > m_free) ? fo - m_free : 0;
    p = m_pend + int'(acc) - d;
    if (p < 0) p = 0;
    if (p > SLOTS) p = SLOTS;
    m_pend = p;
  endtask

  task automatic drive(input logic [7:0] sf, input bit req, input bit cp);
    @(negedge clk);
    rst_n = 1'b1;
    bus.slot_free  = sf;
    bus.entry_req  = req;
    bus.car_passed = cp;
    model_step(sf, req, cp);
    push_exp();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.entry_req  = 1'b0;
    bus.car_passed = 1'b0;
    #1;
    chk("rst_async_gate_open", bus.gate_open, 0);
    chk("rst_async_full", bus.full, 1);
    model_reset();
    push_exp();
  endtask

  task automatic admit_car(input logic [7:0] sf);
    drive(sf, 1, 0);
    drive(sf, 0, 0);
    drive(sf, 0, 1);
    drive(sf, 0, 0);
    drive(sf, 0, 0);
  endtask

  // monitor: one expectation per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("free_cnt",   bus.free_cnt,   e.free_c);
        chk("parked_cnt", bus.parked_cnt, e.parked);
        chk("avail_cnt",  bus.avail_cnt,  e.avail);
        chk("full",       bus.full,       e.full);
        chk("gate_open",  bus.gate_open,  e.gate);
        chk("entry_deny", bus.entry_deny, e.deny);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sf;
    bit req;
    bus.slot_free  = 8'h0F;
    bus.entry_req  = 1'b0;
    bus.car_passed = 1'b0;
    model_reset();

    // reset release with half the lot free
    apply_reset();
    repeat (5) drive(8'h0F, 0, 0);

    // grant, car passes, car parks
    apply_reset();
    repeat (4) drive(8'hFF, 0, 0);
    drive(8'hFF, 1, 0);
    drive(8'hFF, 1, 0);
    drive(8'hFF, 1, 0);
    drive(8'hFF, 0, 1);
    drive(8'hFF, 0, 0);
    repeat (4) drive(8'hFE, 0, 0);

    // lot full through an in-transit car: deny once, held level gives no more
    apply_reset();
    repeat (4) drive(8'h01, 0, 0);
    admit_car(8'h01);
    drive(8'h01, 1, 0);
    repeat (3) drive(8'h01, 1, 0);
    drive(8'h01, 0, 0);

    // timeout without car_passed, then re-request right after CLOSE
    apply_reset();
    repeat (4) drive(8'hFF, 0, 0);
    drive(8'hFF, 1, 0);
    repeat (5) drive(8'hFF, 0, 0);
    drive(8'hFF, 1, 0);
    repeat (7) drive(8'hFF, 0, 0);

    // car_passed in the same cycle as a free count drop of two
    apply_reset();
    repeat (4) drive(8'hFF, 0, 0);
    admit_car(8'hFF);
    admit_car(8'hFF);
    drive(8'hFF, 1, 0);
    drive(8'hFC, 0, 0);
    drive(8'hFC, 0, 0);
    drive(8'hFC, 0, 1);
    repeat (4) drive(8'hFC, 0, 0);

    // reset while the gate is open
    apply_reset();
    repeat (4) drive(8'hFF, 0, 0);
    drive(8'hFF, 1, 0);
    drive(8'hFF, 0, 0);
    apply_reset();
    repeat (4) drive(8'hFF, 0, 0);

    // randomized traffic
    apply_reset();
    sf  = 8'($urandom());
    req = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) sf[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) sf = sf & 8'($urandom());
      if ($urandom_range(0, 3) == 0) req = ~req;
      drive(sf, req, $urandom_range(0, 3) == 0);
      if (i == 400) apply_reset();
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
